// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package axis_arb_pkg;

  localparam int LEN_W = 16;
  localparam int CNT_W = 16;
  localparam int MAX_N = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_result_t;

  // Rotating search: first set bit of req at last_grant+1, +2, ... (mod n).
  function automatic rr_result_t rr_next(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       last_grant,
                                         input int               n);
    rr_result_t res;
    logic [2:0] j;
    res = '{found: 1'b0, idx: 3'd0};
    for (int i = 1; i <= MAX_N; i++) begin
      if (i <= n) begin
        j = 3'((int'(last_grant) + i) % n);
        if (!res.found && req[j]) begin
          res.found = 1'b1;
          res.idx   = j;
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_pkt_arb_if.sv
// Requester-side and buffer-side AXI-Stream signals of the packet arbiter.
interface axis_pkt_arb_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int USER_W = 16
);
  logic [N*DATA_W-1:0] i_req_axis_data;
  logic [N*USER_W-1:0] i_req_axis_user;
  logic [N-1:0]        i_req_axis_valid;
  logic [N-1:0]        i_req_axis_last;
  logic [N-1:0]        o_req_axis_ready;
  logic [DATA_W-1:0]   o_axis_data;
  logic [USER_W-1:0]   o_axis_user;
  logic                o_axis_valid;
  logic                o_axis_last;
  logic                i_axis_ready;

  // Arbiter view.
  modport master (
    input  i_req_axis_data, i_req_axis_user, i_req_axis_valid, i_req_axis_last, i_axis_ready,
    output o_req_axis_ready, o_axis_data, o_axis_user, o_axis_valid, o_axis_last
  );

  // Environment view (requesters and buffer).
  modport slave (
    output i_req_axis_data, i_req_axis_user, i_req_axis_valid, i_req_axis_last, i_axis_ready,
    input  o_req_axis_ready, o_axis_data, o_axis_user, o_axis_valid, o_axis_last
  );
endinterface

// File: rtl/axis_pkt_arb_rr_pick.sv
// Combinational rotating priority encoder: first requester after ptr.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  rr_result_t res_s;

  // Search the request vector starting one position after the pointer.
  always_comb begin
    res_s = rr_next(8'(req), 3'(ptr), N);
  end

  assign idx   = IDX_W'(res_s.idx);
  assign found = res_s.found;

endmodule

// File: rtl/axis_pkt_arb.sv
// Packet-granular round-robin merge of N AXI-Stream requesters into one
// stream, with per-packet beat-count versus declared-length checking.
module axis_pkt_arb
  import axis_arb_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DATA_W = 8,
  parameter  int USER_W = 16,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  axis_pkt_arb_if.master    bus,
  output logic [IDX_W-1:0]  o_grant_id,
  output logic              o_busy,
  output logic              o_len_err,
  output logic [CNT_W-1:0]  o_pkt_cnt
);

  state_e             state_r;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [LEN_W-1:0]   beat_cnt_r;
  logic [LEN_W-1:0]   len_q_r;
  logic               len_err_r;
  logic [CNT_W-1:0]   pkt_cnt_r;

  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_found_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [USER_W-1:0]  sel_user_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic               hs_s;
  logic [LEN_W-1:0]   cur_len_s;
  logic [LEN_W:0]     count_s;
  logic               mismatch_s;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.i_req_axis_valid),
    .ptr   (last_grant_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Select the granted requester and evaluate the end-of-packet length check.
  always_comb begin
    sel_data_s  = bus.i_req_axis_data[grant_r*DATA_W +: DATA_W];
    sel_user_s  = bus.i_req_axis_user[grant_r*USER_W +: USER_W];
    sel_valid_s = bus.i_req_axis_valid[grant_r];
    sel_last_s  = bus.i_req_axis_last[grant_r];
    hs_s        = (state_r == ST_XFER) && sel_valid_s && bus.i_axis_ready;
    // On the first beat len_q is not loaded yet, so use this beat's tuser.
    if (beat_cnt_r == {LEN_W{1'b0}}) begin
      cur_len_s = LEN_W'(sel_user_s);
    end else begin
      cur_len_s = len_q_r;
    end
    // One bit wider so a saturated counter can never match a 16-bit length,
    // and a declared length of zero can never match a count of at least one.
    count_s    = {1'b0, beat_cnt_r} + {{LEN_W{1'b0}}, 1'b1};
    mismatch_s = (count_s != {1'b0, cur_len_s});
  end

  // Drive the merged stream and the per-requester ready only while transferring.
  always_comb begin
    bus.o_axis_data      = {DATA_W{1'b0}};
    bus.o_axis_user      = {USER_W{1'b0}};
    bus.o_axis_valid     = 1'b0;
    bus.o_axis_last      = 1'b0;
    bus.o_req_axis_ready = {N{1'b0}};
    if (state_r == ST_XFER) begin
      bus.o_axis_data               = sel_data_s;
      bus.o_axis_user               = sel_user_s;
      bus.o_axis_valid              = sel_valid_s;
      bus.o_axis_last               = sel_last_s;
      bus.o_req_axis_ready[grant_r] = bus.i_axis_ready;
    end else begin
      bus.o_req_axis_ready = {N{1'b0}};
    end
  end

  // Arbitration FSM with beat/packet counters and the registered error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= {IDX_W{1'b0}};
      last_grant_r <= IDX_W'(N - 1);
      beat_cnt_r   <= {LEN_W{1'b0}};
      len_q_r      <= {LEN_W{1'b0}};
      len_err_r    <= 1'b0;
      pkt_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      len_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_r    <= pick_idx_s;
            beat_cnt_r <= {LEN_W{1'b0}};
            state_r    <= ST_XFER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (hs_s) begin
            if (beat_cnt_r == {LEN_W{1'b0}}) begin
              len_q_r <= LEN_W'(sel_user_s);
            end else begin
              len_q_r <= len_q_r;
            end
            if (sel_last_s) begin
              len_err_r    <= mismatch_s;
              pkt_cnt_r    <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              last_grant_r <= grant_r;
              beat_cnt_r   <= {LEN_W{1'b0}};
              state_r      <= ST_IDLE;
            end else if (beat_cnt_r != {LEN_W{1'b1}}) begin
              beat_cnt_r <= beat_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
              // Saturate; the packet will be flagged when last arrives.
              beat_cnt_r <= beat_cnt_r;
            end
          end else begin
            state_r <= ST_XFER;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant_id = grant_r;
  assign o_busy     = (state_r == ST_XFER);
  assign o_len_err  = len_err_r;
  assign o_pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_axis_pkt_arb.sv
// Directed and randomized checks of axis_pkt_arb against a packet-queue model.
module tb_axis_pkt_arb;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int USER_W = 16;

  typedef struct {
    int          p;
    logic [7:0]  d;
    logic [15:0] u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        len_err;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_arb_if #(.N(N), .DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  axis_pkt_arb #(.N(N), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus.master),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_len_err  (len_err),
    .o_pkt_cnt  (pkt_cnt)
  );

  int    checks = 0;
  int    failures = 0;
  beat_t pend[$];
  int    gap[N];
  int    vmode = 0;
  int    rmode = 0;
  logic  rdy_tgl = 1'b1;
  // Reference model state
  bit    m_busy;
  int    m_grant, m_last, m_cnt, m_len, m_pkts;
  bit    m_err;
  // Observations of the DUT
  int    obs_grants[$];
  bit    prev_busy = 1'b0;
  int    err_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int head(input int k);
    foreach (pend[i]) if (pend[i].p == k) return i;
    return -1;
  endfunction

  task automatic add_pkt(input int p, input int n, input int u, input int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.p = p; b.d = 8'(base + i); b.u = 16'(u); b.l = (i == n - 1);
      pend.push_back(b);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_cnt = 0; m_len = 0; m_pkts = 0; m_err = 1'b0;
    pend.delete();
    foreach (gap[k]) gap[k] = 0;
    prev_busy = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.i_req_axis_data  = '0;
    bus.i_req_axis_user  = '0;
    bus.i_req_axis_valid = '0;
    bus.i_req_axis_last  = '0;
    bus.i_axis_ready     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.o_axis_valid, 0);
    chk({tag, "_last"},  bus.o_axis_last, 0);
    chk({tag, "_data"},  bus.o_axis_data, 0);
    chk({tag, "_user"},  bus.o_axis_user, 0);
    chk({tag, "_ready"}, bus.o_req_axis_ready, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_lenerr"}, len_err, 0);
    chk({tag, "_pktcnt"}, pkt_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step();
    logic [N*DATA_W-1:0] d;
    logic [N*USER_W-1:0] u;
    logic [N-1:0]        v, l, er;
    logic                rdy;
    int                  h, j;
    logic [7:0]          ed;
    logic [15:0]         eu;
    logic                el;
    d = '0; u = '0; v = '0; l = '0;
    for (int k = 0; k < N; k++) begin
      h = head(k);
      if (h >= 0) begin
        d[k*DATA_W +: DATA_W] = pend[h].d;
        u[k*USER_W +: USER_W] = pend[h].u;
        l[k] = pend[h].l;
        v[k] = (gap[k] == 0) && (vmode == 0 || $urandom_range(3) != 0);
      end
    end
    case (rmode)
      0: rdy = 1'b1;
      1: begin rdy = rdy_tgl; rdy_tgl = ~rdy_tgl; end
      default: rdy = 1'($urandom_range(1));
    endcase
    bus.i_req_axis_data = d; bus.i_req_axis_user = u;
    bus.i_req_axis_valid = v; bus.i_req_axis_last = l; bus.i_axis_ready = rdy;
    #1;
    h = m_busy ? head(m_grant) : -1;
    ed = (h >= 0) ? pend[h].d : 8'd0;
    eu = (h >= 0) ? pend[h].u : 16'd0;
    el = (h >= 0) ? pend[h].l : 1'b0;
    er = '0;
    if (m_busy && rdy) er[m_grant] = 1'b1;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_grant);
    chk("out_valid", bus.o_axis_valid, m_busy && v[m_grant]);
    chk("out_data", bus.o_axis_data, ed);
    chk("out_user", bus.o_axis_user, eu);
    chk("out_last", bus.o_axis_last, el);
    chk("req_ready", bus.o_req_axis_ready, er);
    chk("len_err", len_err, m_err);
    chk("pkt_cnt", pkt_cnt, 16'(m_pkts));
    if (busy && !prev_busy) obs_grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (len_err) err_pulses++;
    // Model: advance across the coming clock edge
    m_err = 1'b0;
    if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        j = (m_last + i) % N;
        if (!m_busy && v[j]) begin
          m_busy = 1'b1; m_grant = j; m_cnt = 0;
        end
      end
    end else if (v[m_grant] && rdy) begin
      m_cnt++;
      if (m_cnt == 1) m_len = int'(pend[h].u);
      if (pend[h].l) begin
        m_err = (m_cnt != m_len);
        m_pkts++;
        m_last = m_grant;
        m_busy = 1'b0;
      end
      pend.delete(h);
    end
    foreach (gap[k]) if (gap[k] > 0) gap[k]--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((pend.size() > 0 || m_busy) && n < max) begin
      step();
      n++;
    end
    chk("drain_done", (pend.size() == 0) && !m_busy, 1);
    step();
    step();
  endtask

  initial begin
    int n;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Round-robin from reset: all four ports hold a 3-beat packet
    do_reset();
    obs_grants.delete();
    for (int k = 0; k < N; k++) add_pkt(k, 3, 3, 16 * k);
    drain(100);
    chk("rr_count", obs_grants.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (obs_grants.size() > i) ? obs_grants[i] : -1, i);
    chk("rr_pktcnt", pkt_cnt, 4);

    // Single port, 200 beats, data 1..200
    do_reset();
    err_pulses = 0;
    add_pkt(0, 200, 200, 1);
    drain(400);
    chk("single_pktcnt", pkt_cnt, 1);
    chk("single_noerr", err_pulses, 0);

    // Backpressure: ready alternates during a 10-beat packet
    rmode = 1; rdy_tgl = 1'b1;
    add_pkt(1, 10, 10, 40);
    drain(100);
    rmode = 0;
    chk("bp_pktcnt", pkt_cnt, 2);

    // Length errors: short packet, then zero declared length
    err_pulses = 0;
    add_pkt(1, 5, 6, 60);
    drain(50);
    add_pkt(0, 1, 0, 70);
    drain(50);
    chk("lenerr_pulses", err_pulses, 2);

    // Valid gap on the granted port while port 3 requests
    obs_grants.delete();
    add_pkt(0, 10, 10, 80);
    n = 0;
    while (!(m_busy && m_grant == 0 && m_cnt == 3) && n < 100) begin step(); n++; end
    chk("gap_reached", n < 100, 1);
    gap[0] = 7;
    add_pkt(3, 4, 4, 100);
    drain(100);
    chk("gap_count", obs_grants.size(), 2);
    chk("gap_first", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);
    chk("gap_second", (obs_grants.size() > 1) ? obs_grants[1] : -1, 3);

    // Randomized packets, valid gating, backpressure and length errors
    vmode = 1; rmode = 2;
    for (int i = 0; i < 16; i++) begin
      int len;
      len = int'($urandom_range(6, 1));
      add_pkt(int'($urandom_range(N - 1)), len,
              ($urandom_range(3) == 0) ? int'($urandom_range(7)) : len,
              int'($urandom_range(255)));
    end
    drain(3000);
    vmode = 0; rmode = 0;

    // Asynchronous reset during beat 50 of 200
    do_reset();
    add_pkt(0, 200, 200, 1);
    n = 0;
    while (!(m_busy && m_cnt == 49) && n < 200) begin step(); n++; end
    chk("midrst_reached", n < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    add_pkt(2, 4, 4, 200);
    drain(50);
    chk("post_rst_pktcnt", pkt_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
